mdu_core: RTL and testbench
===========================

MDU_CORE -- requirements
Module: mdu_core

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy duration of multiply-class ops.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy duration of divide-class ops.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  issue strobe; op and operands valid in the same cycle.
REQ-006 SHALL have port MDOp  input  4  op code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu; others treated as none.
REQ-007 SHALL have port A  input  32  rs operand.
REQ-008 SHALL have port B  input  32  rt operand.
REQ-009 SHALL have port busy  output  1  high while an issued op is in progress.
REQ-010 SHALL have port HI  output  32  architectural HI register.
REQ-011 SHALL have port LO  output  32  architectural LO register.

Function
REQ-012 SHALL accept an op only when start=1 and busy=0 at a rising edge; start while busy=1 SHALL be ignored with no state change.
REQ-013 mult/madd/msub SHALL use signed 32x32->64; multu/maddu/msubu SHALL use unsigned 32x32->64.
REQ-014 madd/maddu SHALL write {HI,LO} = {HI,LO} + product; msub/msubu SHALL write {HI,LO} = {HI,LO} - product; 64-bit modulo, no overflow flag; {HI,LO} sampled at accept.
REQ-015 div/divu SHALL write LO = quotient, HI = remainder; signed quotient truncates toward zero and remainder sign follows dividend (A).
REQ-016 div with A=0x80000000, B=0xFFFFFFFF SHALL yield LO=0x80000000, HI=0.
REQ-017 div/divu with B=0 SHALL leave HI and LO unchanged but still hold busy for DIV_CYCLES cycles.
REQ-018 Accepted multiply-class op SHALL raise busy on the cycle after the accepting edge and hold it exactly MULT_CYCLES cycles; divide-class likewise for DIV_CYCLES.
REQ-019 HI/LO SHALL update on the same edge that deasserts busy; until then HI/LO SHALL hold previous values.
REQ-020 Operands and op SHALL be captured at the accepting edge; later changes to A, B, MDOp SHALL not affect the result.
REQ-021 mthi SHALL write HI=A and mtlo SHALL write LO=A on the accepting edge, single cycle, busy stays 0.
REQ-022 start with MDOp none/undefined SHALL change nothing and leave busy=0.
REQ-023 A new op SHALL be accepted on the first edge where busy=0, i.e. the cycle after busy falls; back-to-back ops SHALL chain with madd reading the freshly written HI/LO.
REQ-024 Internal cycle counter SHALL load MULT_CYCLES or DIV_CYCLES on accept, decrement each cycle, busy = (counter != 0), result committed on 1->0 transition.

Reset
REQ-025 reset=1 at a rising edge SHALL set HI=0, LO=0, busy=0, counter=0, pending result discarded.
REQ-026 reset SHALL take priority over start on the same edge; an op in flight at reset SHALL never commit.
REQ-027 First accept after reset SHALL be possible on the edge following the reset edge once reset=0.

Configuration
REQ-028 Macro MDU_MADD_EN SHALL gate ops 7-10 (madd, maddu, msub, msubu).
REQ-029 With MDU_MADD_EN defined, ops 7-10 SHALL behave per REQ-014 with MULT_CYCLES latency.
REQ-030 Without MDU_MADD_EN, ops 7-10 SHALL be treated as none (REQ-022) and the 64-bit accumulate adder SHALL not be synthesised.

Verification
REQ-031 mult A=0xFFFFFFFE(-2), B=3 -> busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-032 div A=0xFFFFFFF9(-7), B=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=0 -> busy 10 cycles, HI/LO unchanged.
REQ-033 mthi A=0x12345678, mtlo A=0x9ABCDEF0 on consecutive edges -> HI=0x12345678, LO=0x9ABCDEF0, busy never high; then madd A=2, B=3 (MDU_MADD_EN) -> LO=0x9ABCDEF6, HI=0x12345678.
REQ-034 start mult while div busy, operands changed mid-op -> second op ignored, div result per captured operands only.
REQ-035 reset asserted in cycle 4 of a div following HI=LO=0x55555555 -> HI=LO=0, busy=0 next cycle, no later commit.
REQ-036 Build without MDU_MADD_EN, start msub A=1, B=1 -> busy stays 0, HI/LO unchanged.

Source files
------------

// File: rtl/mdu_core.sv
// mdu_core: multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Define MDU_MADD_EN to build madd/maddu/msub/msubu; without it those op codes behave as none.
module mdu_core #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  // Handshake: an op is taken when start=1 and busy=0 at a rising edge; start while busy is dropped.
  logic [CW-1:0] count;
  logic [63:0]   pend;
  logic          pend_wr;

  logic          is_signed;
  logic          is_mul;
  logic          is_div;
  logic          a_sx;
  logic          b_sx;
  logic [63:0]   prod;
  logic [63:0]   mul_res;
  logic [31:0]   a_mag;
  logic [31:0]   b_mag;
  logic [31:0]   b_div;
  logic [31:0]   quo_mag;
  logic [31:0]   rem_mag;
  logic [63:0]   div_res;

  always_comb begin
    is_signed = 1'b0;
    is_mul    = 1'b0;
    is_div    = 1'b0;
    case (MDOp)
      OP_MULT:  begin is_mul = 1'b1; is_signed = 1'b1; end
      OP_MULTU: is_mul = 1'b1;
      OP_DIV:   begin is_div = 1'b1; is_signed = 1'b1; end
      OP_DIVU:  is_div = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MSUB:   begin is_mul = 1'b1; is_signed = 1'b1; end
      OP_MADDU, OP_MSUBU: is_mul = 1'b1;
`endif
      default: ;
    endcase
  end

  // One 64-bit multiplier serves both signednesses via operand extension.
  assign a_sx = is_signed & A[31];
  assign b_sx = is_signed & B[31];
  assign prod = {{32{a_sx}}, A} * {{32{b_sx}}, B};

  always_comb begin
    mul_res = prod;
`ifdef MDU_MADD_EN
    if (MDOp == OP_MADD || MDOp == OP_MADDU) begin
      mul_res = {HI, LO} + prod;
    end else if (MDOp == OP_MSUB || MDOp == OP_MSUBU) begin
      mul_res = {HI, LO} - prod;
    end
`endif
  end

  // Signed divide runs on magnitudes; 0x80000000 / -1 falls out as quotient 0x80000000, remainder 0.
  assign a_mag   = a_sx ? (32'd0 - A) : A;
  assign b_mag   = b_sx ? (32'd0 - B) : B;
  assign b_div   = (B == 32'd0) ? 32'd1 : b_mag;
  assign quo_mag = a_mag / b_div;
  assign rem_mag = a_mag % b_div;
  assign div_res = {a_sx ? (32'd0 - rem_mag) : rem_mag,
                    (a_sx ^ b_sx) ? (32'd0 - quo_mag) : quo_mag};

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      pend    <= '0;
      pend_wr <= 1'b0;
      HI      <= '0;
      LO      <= '0;
    end else if (count != '0) begin
      count <= count - CW'(1);
      if (count == CW'(1) && pend_wr) begin
        {HI, LO} <= pend;
      end
    end else if (start) begin
      if (is_mul) begin
        count   <= CW'(MULT_CYCLES);
        pend    <= mul_res;
        pend_wr <= 1'b1;
      end else if (is_div) begin
        count   <= CW'(DIV_CYCLES);
        pend    <= div_res;
        pend_wr <= (B != 32'd0);
      end else if (MDOp == OP_MTHI) begin
        HI <= A;
      end else if (MDOp == OP_MTLO) begin
        LO <= A;
      end
    end
  end

  assign busy = (count != '0);

endmodule

// File: tb/tb_mdu_core.sv
// tb_mdu_core: randomized and directed stimulus for mdu_core with an arithmetic reference model
// feeding an expected queue; a negedge monitor pops and compares when ops complete.
module tb_mdu_core;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  MDOp  = 4'd0;
  logic [31:0] A     = 32'd0;
  logic [31:0] B     = 32'd0;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];
  int          lat_q[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  int run     = 0;
  bit imm_due = 1'b0;

  mdu_core #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .MDOp(MDOp), .A(A), .B(B),
    .busy(busy), .HI(HI), .LO(LO)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic bit is_long(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return (op >= 4'd1 && op <= 4'd4) || (op >= 4'd7 && op <= 4'd10);
`else
    return (op >= 4'd1 && op <= 4'd4);
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // reference model: architectural result of one accepted op
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] acc, r, sp, up;
    longint la, lb;
    int sa, sb, lat;
    acc = {m_hi, m_lo};
    r   = acc;
    lat = 0;
    sa  = a;
    sb  = b;
    la  = sa;
    lb  = sb;
    sp  = la * lb;
    up  = {32'd0, a} * {32'd0, b};
    case (op)
      4'd1: begin r = sp; lat = MC; end
      4'd2: begin r = up; lat = MC; end
      4'd3: begin
        lat = DC;
        if (b != 32'd0) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
          else r = {32'(sa % sb), 32'(sa / sb)};
        end
      end
      4'd4: begin
        lat = DC;
        if (b != 32'd0) r = {a % b, a / b};
      end
      4'd5: r = {a, m_lo};
      4'd6: r = {m_hi, a};
`ifdef MDU_MADD_EN
      4'd7:  begin r = acc + sp; lat = MC; end
      4'd8:  begin r = acc + up; lat = MC; end
      4'd9:  begin r = acc - sp; lat = MC; end
      4'd10: begin r = acc - up; lat = MC; end
`endif
      default: ;
    endcase
    {m_hi, m_lo} = r;
    exp_q.push_back(r);
    lat_q.push_back(lat);
  endtask

  // driver tasks: called and return at posedge+#1
  task automatic wait_idle();
    int g = 0;
    while (busy && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout busy=%0b required=0", busy);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    wait_idle();
    start = 1'b1;
    MDOp  = op;
    A     = a;
    B     = b;
    model(op, a, b);
    @(posedge clk); #1;
    start = 1'b0;
    MDOp  = 4'($urandom_range(0, 15));
    A     = $urandom;
    B     = $urandom;
  endtask

  task automatic do_reset(input bit with_start);
    reset = 1'b1;
    start = with_start;
    MDOp  = 4'd5;
    A     = 32'hDEAD_BEEF;
    B     = 32'd0;
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b0;
    m_hi  = 32'd0;
    m_lo  = 32'd0;
    check("reset_hi", 64'(HI), 64'd0);
    check("reset_lo", 64'(LO), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] ext [6];
    ext = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'h7FFF_FFFF, 32'hFFFF_FFFE};
    case ($urandom_range(0, 3))
      0: return ext[$urandom_range(0, 5)];
      1: return $urandom_range(0, 1) ? 32'($urandom_range(0, 20)) : 32'd0 - 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // scoreboard monitor
  task automatic pop_check(input string name, input int run_len);
    logic [63:0] e;
    int l;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_underflow actual=completion required=none", name);
      return;
    end
    e = exp_q.pop_front();
    l = lat_q.pop_front();
    check({name, "_hilo"}, {HI, LO}, e);
    check({name, "_busy_len"}, 64'(run_len), 64'(l));
  endtask

  always @(negedge clk) begin
    if (reset) begin
      run     = 0;
      imm_due = 1'b0;
    end else begin
      if (imm_due) begin
        pop_check("imm", 0);
        check("imm_busy", 64'(busy), 64'd0);
        imm_due = 1'b0;
      end
      if (busy) run++;
      else if (run > 0) begin
        pop_check("long", run);
        run = 0;
      end
      if (start && !busy && !is_long(MDOp)) imm_due = 1'b1;
    end
  end

  initial begin
    // reset wins over a same-edge mthi
    do_reset(1'b1);

    // signed / unsigned multiply, accepted on the first edge after reset
    issue(4'd1, 32'hFFFF_FFFE, 32'd3);
    wait_idle();
    check("mult_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFA);
    issue(4'd2, 32'hFFFF_FFFE, 32'd3);
    wait_idle();
    check("multu_const", {HI, LO}, 64'h0000_0002_FFFF_FFFA);

    // signed divide, divide by zero, overflow case
    issue(4'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle();
    check("div_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(4'd4, 32'd7, 32'd0);
    wait_idle();
    check("divu_zero_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();
    check("div_ovf_const", {HI, LO}, 64'h0000_0000_8000_0000);

    // moves on consecutive edges, then accumulate
    issue(4'd5, 32'h1234_5678, 32'd0);
    check("mthi_busy", 64'(busy), 64'd0);
    issue(4'd6, 32'h9ABC_DEF0, 32'd0);
    check("mtlo_busy", 64'(busy), 64'd0);
    check("mthi_mtlo_const", {HI, LO}, 64'h1234_5678_9ABC_DEF0);
`ifdef MDU_MADD_EN
    issue(4'd7, 32'd2, 32'd3);
    wait_idle();
    check("madd_const", {HI, LO}, 64'h1234_5678_9ABC_DEF6);
`else
    issue(4'd9, 32'd1, 32'd1);
    check("msub_off_busy", 64'(busy), 64'd0);
    check("msub_off_const", {HI, LO}, 64'h1234_5678_9ABC_DEF0);
`endif

    // start while busy is ignored; operands change mid-op
    issue(4'd3, 32'd1000, 32'd7);
    start = 1'b1;
    MDOp  = 4'd1;
    repeat (3) begin
      A = $urandom;
      B = $urandom;
      @(posedge clk); #1;
    end
    start = 1'b0;
    wait_idle();
    check("div_while_busy_const", {HI, LO}, {32'd6, 32'd142});

    // reset in the middle of a divide discards the pending result
    issue(4'd5, 32'h5555_5555, 32'd0);
    issue(4'd6, 32'h5555_5555, 32'd0);
    issue(4'd3, 32'd1000, 32'd3);
    repeat (2) @(posedge clk);
    #1;
    check("hold_during_busy", {HI, LO}, 64'h5555_5555_5555_5555);
    void'(exp_q.pop_back());
    void'(lat_q.pop_back());
    do_reset(1'b0);
    repeat (15) @(posedge clk);
    #1;
    check("no_late_commit", {HI, LO}, 64'd0);
    check("no_late_busy", 64'(busy), 64'd0);

    // randomized traffic, chained back to back with occasional gaps
    for (int i = 0; i < 60; i++) begin
      logic [3:0] op;
      logic [31:0] a, b;
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 10));
      a  = pick_operand();
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : pick_operand();
      issue(op, a, b);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    wait_idle();
    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
